div_unit: RTL
=============

# div_unit

Multicycle signed integer divider that sits beside the execute stage and feeds the writeback port of the 5-stage pipeline. Execute launches a `div` with a one-cycle start pulse; the unit stalls fetch/decode while iterating, then presents a one-cycle write request (result, destination register, error flag) that the writeback mux services with priority over the normal MW path. A divide-by-zero raises `error` so the pipeline can insert the `$rstatus` write.

## Interface
- `WIDTH`, 32: operand and result width in bits.
- `REGW`, 5: destination register tag width.

- `clock`  in  1: master clock, all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state.
- `start`  in  1: launch request, sampled only in IDLE.
- `dividend`  in  WIDTH: signed two's-complement numerator (operand A).
- `divisor`  in  WIDTH: signed two's-complement denominator (operand B).
- `dest_reg`  in  REGW: destination register of the `div` (IR[26:22]).
- `busy`  out  1: high while iterating; ORed into the fetch/decode stall.
- `write`  out  1: one-cycle writeback request.
- `result`  out  WIDTH: quotient; valid only when `write`=1, else 0.
- `error`  out  1: divide-by-zero flag; valid only when `write`=1, else 0.
- `reg_out`  out  REGW: destination tag; valid only when `write`=1, else 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 captures `dest_reg` and operand signs, loads |dividend| and |divisor|, and clears the remainder and the 6-bit step counter.
  - divisor==0: go to DONE with error latched 1 and quotient 0.
  - otherwise: go to RUN.
- RUN: one restoring step per cycle. Shift {rem,quo} left 1. If rem ≥ |divisor|, subtract it and set quo[0]=1. Increment counter. After the 32nd step, go to DONE.
- DONE: drives `write`=1, `result`, `error`, `reg_out`. Returns to IDLE on the next edge.
- Sign fix: quotient is negated iff the dividend and divisor signs differ. Truncation is toward zero, so -7/2 = -3. The remainder is discarded.
- Overflow 0x80000000 / -1: result is 0x80000000 (two's-complement wrap), error=0.
- Absolute values are computed in WIDTH+1 bits so |0x80000000| is exact. Subtraction is also WIDTH+1 bits.
- `start` while in RUN or DONE is ignored. No queuing; the pipeline holds the `div` via `busy`.
- Reset in any state: go to IDLE, all outputs 0, no `write` pulse issued for the aborted op.

## Timing
- Reset values: `busy`=0, `write`=0, `result`=0, `error`=0, `reg_out`=0, state IDLE.
- `start` sampled high at edge E0 (nonzero divisor):
  - RUN on edges E0..E31; `busy`=1 for cycles after E0 through E32.
  - DONE entered at E32; `write`=1 for exactly the cycle between E32 and E33.
  - IDLE at E33, so a new `start` is accepted at E33 at the earliest.
  - Latency: 33 cycles start-to-write.
- Divide-by-zero: DONE entered at E0, `write`=1 with `error`=1 during the following cycle, IDLE at E1. `busy` never asserts.
- `busy` and `write` are never high in the same cycle.
- Outputs are registered state decodes; no combinational path from inputs to outputs.
- `start` and `write` in the same cycle: the start is ignored because the unit is in DONE, not IDLE.

## Test plan
- 100 / 7 with dest 5 -> `write` exactly 33 cycles after start, `result`=14, `error`=0, `reg_out`=5; `busy` high for 32 cycles.
- -100 / 7 and 7 / -2 -> `result`=0xFFFFFFF2 (-14) and 0xFFFFFFFD (-3) respectively; -8 / -2 -> 4.
- 7 / 0 with dest 9 -> `write` the cycle after start, `error`=1, `result`=0, `reg_out`=9, `busy` never high.
- 0x80000000 / -1 -> `result`=0x80000000, `error`=0; 0x80000000 / 1 -> 0x80000000; 0 / 5 -> 0.
- Reset asserted at cycle 10 of a RUN -> next cycle all outputs 0, no `write` pulse; a fresh 20 / 4 then yields 5 after 33 cycles.
- Back-to-back: start held high continuously -> second op accepted only at the IDLE edge after the first `write`. Extra starts during RUN/DONE produce no extra `write` pulses.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multicycle signed restoring divider with a one-cycle writeback request
module div_unit #(
  parameter int WIDTH = 32,
  parameter int REGW = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [REGW-1:0]  dest_reg,
  output logic             busy,
  output logic             write,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic [REGW-1:0]  reg_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [5:0] cnt;
  logic [WIDTH:0] rem, dvs, a_ext, b_ext, a_abs, b_abs, rem_s;
  logic [WIDTH-1:0] quo;
  logic neg, err, ge, zero;
  logic [REGW-1:0] tag;
  // magnitudes carry one extra bit so the most negative operand stays exact
  assign a_ext = {dividend[WIDTH-1], dividend};
  assign b_ext = {divisor[WIDTH-1], divisor};
  assign a_abs = a_ext[WIDTH] ? -a_ext : a_ext;
  assign b_abs = b_ext[WIDTH] ? -b_ext : b_ext;
  assign zero = divisor == '0;
  assign rem_s = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign ge = rem_s >= dvs;
  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // next state: divide-by-zero skips iteration, DONE always lasts one cycle
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = zero ? DONE : RUN;
    else if (state == RUN && cnt == 6'(WIDTH - 1)) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  // operand capture in IDLE, one restoring step per RUN cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      rem <= '0;
      dvs <= '0;
      quo <= '0;
      cnt <= '0;
      neg <= 1'b0;
      err <= 1'b0;
      tag <= '0;
    end else if (state == IDLE && start) begin
      rem <= '0;
      dvs <= b_abs;
      quo <= zero ? '0 : a_abs[WIDTH-1:0];
      cnt <= '0;
      neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      err <= zero;
      tag <= dest_reg;
    end else if (state == RUN) begin
      rem <= ge ? rem_s - dvs : rem_s;
      quo <= {quo[WIDTH-2:0], ge};
      cnt <= cnt + 6'd1;
    end
  end
  assign busy = state == RUN;
  assign write = state == DONE;
  assign result = write ? (neg ? -quo : quo) : '0;
  assign error = write & err;
  assign reg_out = write ? tag : '0;
endmodule
